alu_exec_stage: RTL

- EX-stage execution unit directly downstream of the ALU-control decoder. It consumes the 4-bit ALUcontrol code plus two operands and produces a registered result, zero and overflow flags for the EX/MEM boundary.
- Single-cycle ops complete in 1 cycle. MUL (low word) is iterative shift-add over WIDTH cycles.
- Valid/ready handshakes on both sides let the hazard logic stall upstream while a multiply is in flight.

---
 rtl/alu_exec_stage_if.sv | 33 +++
 rtl/alu_exec_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage_if.sv
// Operand/result bus of the EX-stage ALU: valid/ready on the issue side
// and on the EX/MEM side.
interface alu_exec_stage_if #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUcontrol;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [RD_W-1:0]  rd_in;
    logic             reg_write_in;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic [RD_W-1:0]  rd_out;
    logic             reg_write_out;

    modport master (
        output in_valid, ALUcontrol, op_a, op_b, rd_in, reg_write_in, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal, rd_out, reg_write_out
    );

    modport slave (
        input  in_valid, ALUcontrol, op_a, op_b, rd_in, reg_write_in, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal, rd_out, reg_write_out
    );
endinterface

// File: rtl/alu_exec_stage.sv
// EX-stage execution unit: single-cycle logic/arith ops plus an iterative
// shift-add multiplier, with a registered result slot toward EX/MEM.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    alu_exec_stage_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [RD_W-1:0]  mul_rd;
    logic             mul_rw;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             overflow_q;
    logic             illegal_q;
    logic [RD_W-1:0]  rd_q;
    logic             rw_q;

    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;

    assign slot_free    = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (state == S_IDLE) && slot_free && !flush && !reset;
    assign accept       = bus.in_valid && bus.in_ready;

    assign sum  = bus.op_a + bus.op_b;
    assign diff = bus.op_a - bus.op_b;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (bus.ALUcontrol)
            OP_AND: alu_res = bus.op_a & bus.op_b;
            OP_OR:  alu_res = bus.op_a | bus.op_b;
            OP_NOR: alu_res = ~(bus.op_a | bus.op_b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            OP_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
        end else if (flush) begin
            state       <= S_IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // A consumed result leaves the slot unless a new one lands this edge.
            if (slot_free)
                out_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.ALUcontrol == OP_MUL) begin
                            mcand  <= bus.op_a;
                            mplier <= bus.op_b;
                            acc    <= '0;
                            cnt    <= '0;
                            mul_rd <= bus.rd_in;
                            mul_rw <= bus.reg_write_in;
                            state  <= S_MUL;
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            overflow_q  <= alu_ovf;
                            illegal_q   <= alu_ill;
                            rd_q        <= bus.rd_in;
                            rw_q        <= bus.reg_write_in && !alu_ill;
                        end
                    end
                end
                S_MUL: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER)
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (slot_free) begin
                        out_valid_q <= 1'b1;
                        result_q    <= acc;
                        zero_q      <= (acc == '0);
                        overflow_q  <= 1'b0;
                        illegal_q   <= 1'b0;
                        rd_q        <= mul_rd;
                        rw_q        <= mul_rw;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: multiplier datapath registers are not reset; they are always loaded before use.

    assign bus.out_valid     = out_valid_q;
    assign bus.result        = result_q;
    assign bus.zero          = zero_q;
    assign bus.overflow      = overflow_q;
    assign bus.illegal       = illegal_q;
    assign bus.rd_out        = rd_q;
    assign bus.reg_write_out = rw_q;
endmodule
